// File: rtl/sys_ctrl_pkg.sv
// Shared system-controller types: FSM state encoding and frame sizing helper.
package sys_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Number of data_w-wide bytes needed to carry an alu_w-wide value.
  function automatic int unsigned nbytes(input int unsigned alu_w, input int unsigned data_w);
    return (alu_w + data_w - 1) / data_w;
  endfunction

endpackage

// File: rtl/sys_ctrl_tx_framer_if.sv
// Register-file/ALU capture side and UART TX byte side of the transmit framer.
interface sys_ctrl_tx_framer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ALU_W  = 16
);

  logic [ALU_W-1:0]  alu_out;
  logic              alu_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              tx_busy;
  logic              tx_data_valid;
  logic [DATA_W-1:0] tx_p_data;
  logic              ready;
  logic              frame_done;
  logic              overrun;

  // Environment side: sources the strobes and the UART busy flag.
  modport master (
    output alu_out, alu_valid, rd_data, rd_valid, tx_busy,
    input  tx_data_valid, tx_p_data, ready, frame_done, overrun
  );

  // Framer side.
  modport slave (
    input  alu_out, alu_valid, rd_data, rd_valid, tx_busy,
    output tx_data_valid, tx_p_data, ready, frame_done, overrun
  );

endinterface

// File: rtl/sys_ctrl_tx_framer_shifter.sv
// Load/shift/count datapath: holds the padded frame and presents the current byte.
module sys_ctrl_tx_framer_shifter
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ALU_W     = 16,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_rd,
  input  logic              load_alu,
  input  logic              shift,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [ALU_W-1:0]  alu_out,
  output logic [DATA_W-1:0] byte_out,
  output logic              last_c
);

  localparam int unsigned NBYTES = nbytes(ALU_W, DATA_W);
  localparam int unsigned SREG_W = NBYTES * DATA_W;
  localparam int unsigned CNT_W  = $clog2(NBYTES + 1);

  logic [SREG_W-1:0] sreg;
  logic [CNT_W-1:0]  count;
  logic [SREG_W-1:0] rd_load_c;
  logic [SREG_W-1:0] alu_load_c;
  logic [SREG_W-1:0] shifted_c;

  // Load images and next-byte shift; a read byte sits where the first byte goes out.
  always_comb begin
    alu_load_c = SREG_W'(alu_out);
    if (LSB_FIRST != 0) begin
      rd_load_c = SREG_W'(rd_data);
      shifted_c = sreg >> DATA_W;
    end else begin
      rd_load_c = SREG_W'(rd_data) << (SREG_W - DATA_W);
      shifted_c = sreg << DATA_W;
    end
  end

  // Frame register and remaining-byte counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg  <= '0;
      count <= '0;
    end else if (load_rd) begin
      sreg  <= rd_load_c;
      count <= CNT_W'(1);
    end else if (load_alu) begin
      sreg  <= alu_load_c;
      count <= CNT_W'(NBYTES);
    end else if (shift) begin
      sreg  <= shifted_c;
      count <= count - CNT_W'(1);
    end
  end

  assign byte_out = (LSB_FIRST != 0) ? sreg[DATA_W-1:0] : sreg[SREG_W-1 -: DATA_W];
  assign last_c   = (count == CNT_W'(1));

endmodule

// File: rtl/sys_ctrl_tx_framer.sv
// Transmit framer: captures a read word or ALU result and feeds it byte-wise to the UART TX.
module sys_ctrl_tx_framer
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ALU_W     = 16,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic clk,
  input  logic rst,
  sys_ctrl_tx_framer_if.slave bus
);

  state_t            state;
  state_t            nxt_state;
  logic              valid_q;
  logic              ready_q;
  logic              done_q;
  logic              ovr_q;
  logic              nxt_valid;
  logic              nxt_ready;
  logic              nxt_done;
  logic              nxt_ovr;
  logic              load_rd;
  logic              load_alu;
  logic              shift;
  logic              last_c;
  logic [DATA_W-1:0] tx_byte;

  sys_ctrl_tx_framer_shifter #(
    .DATA_W    (DATA_W),
    .ALU_W     (ALU_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load_rd  (load_rd),
    .load_alu (load_alu),
    .shift    (shift),
    .rd_data  (bus.rd_data),
    .alu_out  (bus.alu_out),
    .byte_out (tx_byte),
    .last_c   (last_c)
  );

  // State and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state   <= nxt_state;
      valid_q <= nxt_valid;
      ready_q <= nxt_ready;
      done_q  <= nxt_done;
      ovr_q   <= nxt_ovr;
    end
  end

  // Next state, datapath controls and next output values; busy seen in SEND is acceptance.
  always_comb begin
    nxt_state = state;
    nxt_valid = 1'b0;
    nxt_done  = 1'b0;
    nxt_ovr   = 1'b0;
    load_rd   = 1'b0;
    load_alu  = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rd_valid) begin
          load_rd   = 1'b1;
          nxt_state = SEND;
          nxt_valid = 1'b1;
          nxt_ovr   = bus.alu_valid;
        end else if (bus.alu_valid) begin
          load_alu  = 1'b1;
          nxt_state = SEND;
          nxt_valid = 1'b1;
        end
      end
      SEND: begin
        nxt_ovr = bus.rd_valid | bus.alu_valid;
        if (bus.tx_busy) begin
          nxt_state = WAIT;
        end else begin
          nxt_valid = 1'b1;
        end
      end
      WAIT: begin
        nxt_ovr = bus.rd_valid | bus.alu_valid;
        if (!bus.tx_busy) begin
          if (last_c) begin
            nxt_state = IDLE;
            nxt_done  = 1'b1;
          end else begin
            shift     = 1'b1;
            nxt_state = SEND;
            nxt_valid = 1'b1;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
    nxt_ready = (nxt_state == IDLE);
  end

  assign bus.tx_data_valid = valid_q;
  assign bus.tx_p_data     = tx_byte;
  assign bus.ready         = ready_q;
  assign bus.frame_done    = done_q;
  assign bus.overrun       = ovr_q;

endmodule
